// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int WORD_DEF   = 16;
    localparam int ADDR_W_DEF = WORD_DEF - (WORD_DEF / 8) + 1;

    // Bit positions inside the 3-bit {RW, HB, LB} command.
    localparam int CMD_LB = 0;
    localparam int CMD_HB = 1;
    localparam int CMD_RW = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller bundle of the arbiter, plus its FSM debug tap.
interface mem_arbiter_if #(
    parameter int WORD   = mem_arb_pkg::WORD_DEF,
    parameter int ADDR_W = WORD - (WORD / 8) + 1
);
    import mem_arb_pkg::*;

    // Handshake: a requester holds req_i (with cmd/addr/wdata) as a level until the
    // one-cycle done_o pulse; the slave side finishes a transfer with mc_busy_i & mc_ack_i.
    logic [1:0]             req_i;
    logic [1:0][2:0]        cmd_i;
    logic [1:0][ADDR_W-1:0] addr_i;
    logic [1:0][WORD-1:0]   wdata_i;
    logic [1:0]             gnt_o;
    logic [1:0]             done_o;
    logic                   err_o;
    logic [WORD-1:0]        rdata_o;
    logic                   mc_en_o;
    logic [2:0]             mc_cmd_o;
    logic [ADDR_W-1:0]      mc_addr_o;
    logic [WORD-1:0]        mc_data_o;
    logic                   mc_busy_i;
    logic                   mc_ack_i;
    logic [WORD-1:0]        mc_data_i;
    arb_state_e             dbg_state;

    modport master (
        output req_i, cmd_i, addr_i, wdata_i, mc_busy_i, mc_ack_i, mc_data_i,
        input  gnt_o, done_o, err_o, rdata_o, mc_en_o, mc_cmd_o, mc_addr_o,
               mc_data_o, dbg_state
    );

    modport slave (
        input  req_i, cmd_i, addr_i, wdata_i, mc_busy_i, mc_ack_i, mc_data_i,
        output gnt_o, done_o, err_o, rdata_o, mc_en_o, mc_cmd_o, mc_addr_o,
               mc_data_o, dbg_state
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick with a last-granted pointer; pointer resets to 1 so
// requester 0 wins the first tie.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        last_d = last_q;
        if (upd_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/data requesters onto one memory controller, one transfer at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD   = WORD_DEF,
    parameter int ADDR_W = WORD - (WORD / 8) + 1
) (
    input logic          clk_i,
    input logic          rst_ni,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic              mc_en_q, mc_en_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD-1:0]   wdata_q, wdata_d;
    logic [WORD-1:0]   rdata_q, rdata_d;

    logic [1:0] pick;
    logic       accept;
    logic       sel;

    rr_arbiter_2 u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (bus.req_i),
        .upd_i  (accept),
        .gnt_o  (pick)
    );

    assign sel = pick[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        mc_en_d = 1'b0;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((bus.req_i != 2'b00) && !bus.mc_busy_i) begin
                    accept  = 1'b1;
                    gnt_d   = pick;
                    cmd_d   = bus.cmd_i[sel];
                    addr_d  = bus.addr_i[sel];
                    wdata_d = bus.wdata_i[sel];
                    // No byte lane selected: answer with an error without touching memory.
                    if (bus.cmd_i[sel][CMD_HB] || bus.cmd_i[sel][CMD_LB]) begin
                        state_d = ST_ISSUE;
                        mc_en_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        done_d  = pick;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mc_busy_i && bus.mc_ack_i) begin
                    if (!cmd_q[CMD_RW]) begin
                        rdata_d = bus.mc_data_i;
                    end
                    state_d = ST_RELEASE;
                    done_d  = gnt_q;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            mc_en_q <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mc_en_q <= mc_en_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.mc_en_o   = mc_en_q;
    assign bus.mc_cmd_o  = cmd_q;
    assign bus.mc_addr_o = addr_q;
    assign bus.mc_data_o = wdata_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD, default 16, data word width.
REQ-002 Parameter ADDR_W, default WORD-(WORD/8)+1 (15), transfer address width.
REQ-003 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low; the block has one clock and this asynchronous active-low reset.
REQ-005 req_i  input  2  per-requester transfer request (bit 0 fetch, bit 1 data), level, held until done_o.
REQ-006 cmd_i  input  2x3  per-requester command {RW, HB, LB}; RW=1 write, HB/LB byte lanes.
REQ-007 addr_i  input  2xADDR_W  per-requester transfer address.
REQ-008 wdata_i  input  2xWORD  per-requester write data.
REQ-009 gnt_o  output  2  one-hot grant, high from ISSUE through RELEASE inclusive.
REQ-010 done_o  output  2  one-cycle completion pulse to the granted requester.
REQ-011 err_o  output  1  high with done_o when the command was rejected.
REQ-012 rdata_o  output  WORD  read data, valid with done_o, held until next read completion.
REQ-013 mc_en_o  output  1  transfer start to memory controller.
REQ-014 mc_cmd_o  output  3  latched command to memory controller.
REQ-015 mc_addr_o  output  ADDR_W  latched address to memory controller.
REQ-016 mc_data_o  output  WORD  latched write data to memory controller.
REQ-017 mc_busy_i  input  1  memory controller busy.
REQ-018 mc_ack_i  input  1  bus acknowledge, snooped from slave.
REQ-019 mc_data_i  input  WORD  read data from memory controller.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RELEASE.
REQ-021 IDLE: when any req_i bit is set and mc_busy_i=0, the arbiter SHALL pick a winner, latch its cmd/addr/wdata, and go to ISSUE (or to RELEASE for rejected commands, REQ-026).
REQ-022 Winner selection SHALL be round-robin: single requester wins outright; if both request, the one not granted last wins; the last-granted pointer resets to 1, so fetch wins the first tie.
REQ-023 ISSUE: mc_en_o SHALL be 1 for exactly one cycle, then go to WAIT.
REQ-024 WAIT: on mc_busy_i=1 and mc_ack_i=1, capture mc_data_i into rdata_o if the latched RW=0 (writes leave rdata_o unchanged), then go to RELEASE.
REQ-025 RELEASE: done_o of the winner SHALL be 1 for this single cycle; next state IDLE; gnt_o clears after this cycle.
REQ-026 Commands with HB=LB=0 SHALL NOT be forwarded: IDLE goes directly to RELEASE with err_o=1, mc_en_o stays 0.
REQ-027 mc_cmd_o/mc_addr_o/mc_data_o SHALL be driven from latched registers and stay stable from ISSUE through RELEASE, regardless of requester inputs.
REQ-028 Minimum latency SHALL be 3 cycles from req sample in IDLE to done_o, with a zero-wait-state slave.
REQ-029 A req_i still high in the cycle after its done_o SHALL be treated as a new request.
REQ-030 Request inputs SHALL be ignored outside IDLE; at most one transfer is in flight.
REQ-031 No timeout: WAIT SHALL hold indefinitely until ack.

Reset
REQ-032 rst_ni low SHALL immediately force state IDLE, gnt_o=0, done_o=0, err_o=0, mc_en_o=0, rdata_o=0, latched cmd/addr/data=0, and pointer=1.
REQ-033 Reset mid-transfer SHALL abandon the transfer without emitting done_o; after release, the first accept obeys REQ-021.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum, the cmd bit indices (LB=0, HB=1, RW=2), and the WORD/ADDR_W defaults.
REQ-035 Sub-module rr_arbiter_2 SHALL implement the combinational pick plus the last-granted pointer register.

Verification
REQ-036 Fetch read only, cmd=3'b011, addr=15'h0010, slave returns 16'hBEEF zero-wait -> mc_en_o 1 cycle, done_o=2'b01 at +3 cycles, rdata_o=16'hBEEF, err_o=0.
REQ-037 Both request in the same cycle, twice in a row -> grants in order fetch, data, fetch; never two gnt_o bits high.
REQ-038 Data write, cmd=3'b111, wdata=16'h1234, slave acks after 4 waits -> mc_data_o=16'h1234 stable throughout, done_o=2'b10, rdata_o unchanged.
REQ-039 cmd=3'b100 from data port -> done_o=2'b10 with err_o=1 after 1 cycle, mc_en_o never asserted.
REQ-040 rst_ni low during WAIT -> outputs at reset values asynchronously, no done_o; a new request after release completes normally.
